// File: rtl/rst_seq.sv
// rst_seq: staged release of active-low domain resets, one stage at a time.
// Each release waits for a synchronized per-stage ack, with a timeout fault.
// Define RST_SEQ_ACK_CHECK_EN to enable ack checking and the timeout fault.
// Without it, acks are ignored and every stage is treated as ready at once.
module rst_seq #(
    parameter int g_NUM_STAGES  = 4,
    parameter int g_HOLD_CYCLES = 8,
    parameter int g_STAGE_DELAY = 4,
    parameter int g_ACK_TIMEOUT = 32
) (
    input  logic                    clk_sys_i,
    input  logic                    sys_rst_i,
    input  logic                    rst_req_i,
    input  logic [g_NUM_STAGES-1:0] stage_ack_i,
    output logic [g_NUM_STAGES-1:0] stage_rstn_o,
    output logic                    done_o,
    output logic                    timeout_o,
    output logic [((g_NUM_STAGES > 1) ? $clog2(g_NUM_STAGES) : 1)-1:0] fail_stage_o
);
    localparam int SW   = (g_NUM_STAGES > 1) ? $clog2(g_NUM_STAGES) : 1;
    localparam int MAXH = (g_HOLD_CYCLES > g_STAGE_DELAY) ? g_HOLD_CYCLES : g_STAGE_DELAY;
    localparam int MAXC = (MAXH > g_ACK_TIMEOUT) ? MAXH : g_ACK_TIMEOUT;
    localparam int CW   = $clog2(MAXC + 1);
    localparam logic [CW-1:0] HOLD_M1 = CW'(g_HOLD_CYCLES - 1);
    localparam logic [CW-1:0] DLY_M1  = CW'(g_STAGE_DELAY - 1);
    localparam logic [CW-1:0] TO_M1   = CW'(g_ACK_TIMEOUT - 1);
    localparam logic [SW-1:0] LAST    = SW'(g_NUM_STAGES - 1);

    typedef enum logic [2:0] {S_HOLD, S_WAIT, S_DELAY, S_DONE, S_FAULT} state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [SW-1:0]           k_q, k_d;
    logic [g_NUM_STAGES-1:0] rstn_q, rstn_d;
    logic                    done_q, done_d;
    logic [g_NUM_STAGES-1:0] ack_s;

`ifdef RST_SEQ_ACK_CHECK_EN
    logic [g_NUM_STAGES-1:0] ack_s1_q, ack_s2_q;
    logic                    timeout_q, timeout_d;
    logic [SW-1:0]           fail_q, fail_d;

    // Two-flop synchronizer: acks may come from other clock domains
    always_ff @(posedge clk_sys_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            ack_s1_q <= '0;
            ack_s2_q <= '0;
        end else begin
            ack_s1_q <= stage_ack_i;
            ack_s2_q <= ack_s1_q;
        end
    end
    assign ack_s = ack_s2_q;

    // Sticky fault flag and index of the stage that never acked
    always_ff @(posedge clk_sys_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            timeout_q <= 1'b0;
            fail_q    <= '0;
        end else begin
            timeout_q <= timeout_d;
            fail_q    <= fail_d;
        end
    end
    // Fault outputs are fully determined by the state being entered
    always_comb begin
        timeout_d = (state_d == S_FAULT);
        fail_d    = (state_d == S_FAULT) ? k_q : '0;
    end
    assign timeout_o    = timeout_q;
    assign fail_stage_o = fail_q;
`else
    logic unused_ack;
    assign unused_ack   = ^stage_ack_i;
    assign ack_s        = '1;
    assign timeout_o    = 1'b0;
    assign fail_stage_o = '0;
`endif

    // State register, shared counter, current stage index and registered outputs
    always_ff @(posedge clk_sys_i or posedge sys_rst_i) begin
        if (sys_rst_i) begin
            state_q <= S_HOLD;
            cnt_q   <= '0;
            k_q     <= '0;
            rstn_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            rstn_q  <= rstn_d;
            done_q  <= done_d;
        end
    end

    // Next state: counter clears on every transition; a soft request overrides everything
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        k_d     = k_q;
        case (state_q)
            S_HOLD: if (cnt_q == HOLD_M1) begin
                state_d = S_WAIT;
                cnt_d   = '0;
                k_d     = '0;
            end
            S_WAIT: if (ack_s[k_q]) begin
                state_d = (k_q == LAST) ? S_DONE : S_DELAY;
                cnt_d   = '0;
            end else if (cnt_q == TO_M1) begin
                state_d = S_FAULT;
                cnt_d   = '0;
            end
            S_DELAY: if (cnt_q == DLY_M1) begin
                state_d = S_WAIT;
                cnt_d   = '0;
                k_d     = k_q + 1'b1;
            end
            default: cnt_d = '0;
        endcase
        if (rst_req_i) begin
            state_d = S_HOLD;
            cnt_d   = '0;
            k_d     = '0;
        end
    end

    // Outputs: release stage k_d when entering WAIT, drop stage k_q on fault, clear all in HOLD
    always_comb begin
        rstn_d = rstn_q;
        if (state_d == S_WAIT && state_q != S_WAIT) rstn_d[k_d] = 1'b1;
        if (state_d == S_FAULT) rstn_d[k_q] = 1'b0;
        if (state_d == S_HOLD) rstn_d = '0;
        done_d = (state_d == S_DONE);
    end

    assign stage_rstn_o = rstn_q;
    assign done_o       = done_q;
endmodule
